// File: rtl/coor_scan_gen.sv
// Raster-scan coordinate generator: it registers each accepted pixel with its
// (x, y) position and a one-cycle write strobe for the downstream address stage.
module coor_scan_gen #(
  parameter int unsigned COLS   = 79,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [6:0]        x,
  output logic [3:0]        y,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          last_col;
  logic          last_row;

  assign pix_ready = (state == RUN);
  assign accept    = pix_valid & pix_ready;
  assign last_col  = (col == CW'(COLS - 1));
  assign last_row  = (row == RW'(ROWS - 1));

  // Scan FSM; abort outranks both the accept and last-pixel detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      x          <= '0;
      y          <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= RUN;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept) begin
            x       <= 7'(col);
            y       <= 4'(row);
            wr_data <= pix_data;
            wr_en   <= 1'b1;
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= DONE;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= !abort;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coor_scan_gen.sv
// Directed bench for coor_scan_gen: inputs change and outputs are sampled on the falling edge.
module tb_coor_scan_gen;
  localparam int unsigned COLS   = 79;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned DATA_W = 8;
  localparam int          NPIX   = 1264;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic [6:0]        x;
  logic [3:0]        y;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int passed = 0;

  coor_scan_gen #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .x(x), .y(y), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({x, y, wr_data} !== 19'd0) $display("FAIL reset_pos: got x=%0d y=%0d d=%0h, want 0 0 0", x, y, wr_data);
    else passed++;
    checks++;
    if ({wr_en, frame_done, busy, pix_ready} !== 4'b0000)
      $display("FAIL reset_ctl: got wr_en/fd/busy/rdy=%b, want 0000", {wr_en, frame_done, busy, pix_ready});
    else passed++;
    rst = 1'b0;
    pix_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({pix_ready, busy, wr_en} !== 3'b000) $display("FAIL idle_no_ready: got rdy/busy/wr=%b, want 000", {pix_ready, busy, wr_en});
    else passed++;
    pix_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    start_frame();
    checks++;
    if ({pix_ready, busy} !== 2'b11) $display("FAIL run_entry: got rdy/busy=%b, want 11", {pix_ready, busy});
    else passed++;
    pix_valid = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      pix_data = 8'(i);
      @(negedge clk);
      checks++;
      if ({wr_en, x, y, wr_data, frame_done} !== {1'b1, 7'(i % COLS), 4'(i / COLS), 8'(i), 1'b0})
        $display("FAIL full_pix %0d: got wr=%0b x=%0d y=%0d d=%0h fd=%0b, want wr=1 x=%0d y=%0d d=%0h fd=0",
                 i, wr_en, x, y, wr_data, frame_done, i % COLS, i / COLS, i % 256);
      else passed++;
    end
    pix_valid = 1'b0;
    checks++;
    if ({x, y, wr_data, pix_ready, busy} !== {7'd78, 4'd15, 8'hEF, 1'b0, 1'b1})
      $display("FAIL last_write: got x=%0d y=%0d d=%0h rdy=%0b busy=%0b, want 78 15 ef 0 1", x, y, wr_data, pix_ready, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if ({frame_done, wr_en, busy, pix_ready} !== 4'b1000)
      $display("FAIL frame_done: got fd/wr/busy/rdy=%b, want 1000", {frame_done, wr_en, busy, pix_ready});
    else passed++;
    @(negedge clk);
    checks++;
    if ({frame_done, busy, pix_ready} !== 3'b000) $display("FAIL frame_done_pulse: got fd/busy/rdy=%b, want 000", {frame_done, busy, pix_ready});
    else passed++;
  endtask

  task automatic test_backpressure();
    int k;
    bit v;
    k = 0;
    start_frame();
    for (int cyc = 0; k < NPIX && cyc < 3 * NPIX; cyc++) begin
      v = (cyc % 2 == 0);
      pix_valid = v;
      pix_data = 8'(k * 3 + 1);
      @(negedge clk);
      checks++;
      if (v) begin
        if ({wr_en, x, y, wr_data} !== {1'b1, 7'(k % COLS), 4'(k / COLS), 8'(k * 3 + 1)})
          $display("FAIL bp_write %0d: got wr=%0b x=%0d y=%0d d=%0h, want wr=1 x=%0d y=%0d d=%0h",
                   k, wr_en, x, y, wr_data, k % COLS, k / COLS, (k * 3 + 1) % 256);
        else passed++;
        k++;
      end else begin
        if ({wr_en, x, y, wr_data} !== {1'b0, 7'((k - 1) % COLS), 4'((k - 1) / COLS), 8'((k - 1) * 3 + 1)})
          $display("FAIL bp_hold %0d: got wr=%0b x=%0d y=%0d d=%0h, want wr=0 x=%0d y=%0d d=%0h",
                   k, wr_en, x, y, wr_data, (k - 1) % COLS, (k - 1) / COLS, ((k - 1) * 3 + 1) % 256);
        else passed++;
      end
    end
    pix_valid = 1'b0;
    checks++;
    if (k !== NPIX) $display("FAIL bp_accepts: got %0d, want %0d", k, NPIX);
    else passed++;
    @(negedge clk);
    checks++;
    if ({frame_done, busy, pix_ready} !== 3'b100) $display("FAIL bp_done: got fd/busy/rdy=%b, want 100", {frame_done, busy, pix_ready});
    else passed++;
  endtask

  task automatic test_abort();
    start_frame();
    pix_valid = 1'b1;
    for (int i = 0; i < 163; i++) begin
      pix_data = 8'(i);
      @(negedge clk);
    end
    pix_data = 8'hA5;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if ({wr_en, x, y, busy, pix_ready, frame_done} !== {1'b0, 7'd4, 4'd2, 3'b000})
      $display("FAIL abort_discard: got wr=%0b x=%0d y=%0d busy=%0b rdy=%0b fd=%0b, want 0 4 2 0 0 0",
               wr_en, x, y, busy, pix_ready, frame_done);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({frame_done, wr_en, busy} !== 3'b000) $display("FAIL abort_quiet %0d: got fd/wr/busy=%b, want 000", i, {frame_done, wr_en, busy});
      else passed++;
    end
    start_frame();
    pix_valid = 1'b1;
    pix_data = 8'h5A;
    @(negedge clk);
    pix_valid = 1'b0;
    checks++;
    if ({wr_en, x, y, wr_data} !== {1'b1, 7'd0, 4'd0, 8'h5A})
      $display("FAIL abort_restart: got wr=%0b x=%0d y=%0d d=%0h, want 1 0 0 5a", wr_en, x, y, wr_data);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    start_frame();
    pix_valid = 1'b1;
    for (int i = 0; i < 277; i++) begin
      pix_data = 8'(i);
      @(negedge clk);
    end
    pix_data = 8'(277);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr_en, x, y, wr_data, busy} !== {1'b1, 7'd40, 4'd3, 8'h15, 1'b1})
      $display("FAIL start_mid_write: got wr=%0b x=%0d y=%0d d=%0h busy=%0b, want 1 40 3 15 1", wr_en, x, y, wr_data, busy);
    else passed++;
    pix_data = 8'(278);
    @(negedge clk);
    pix_valid = 1'b0;
    checks++;
    if ({wr_en, x, y, wr_data} !== {1'b1, 7'd41, 4'd3, 8'h16})
      $display("FAIL start_ignored: got wr=%0b x=%0d y=%0d d=%0h, want 1 41 3 16", wr_en, x, y, wr_data);
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    start_frame();
    pix_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pix_data = 8'(i + 7);
      @(negedge clk);
    end
    checks++;
    if ({wr_en, x, y, busy} !== {1'b1, 7'd20, 4'd1, 1'b1})
      $display("FAIL pre_reset: got wr=%0b x=%0d y=%0d busy=%0b, want 1 20 1 1", wr_en, x, y, busy);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({x, y, wr_en, wr_data, frame_done, busy, pix_ready} !== 23'd0)
      $display("FAIL async_reset: got x=%0d y=%0d wr=%0b d=%0h fd=%0b busy=%0b rdy=%0b, want all 0",
               x, y, wr_en, wr_data, frame_done, busy, pix_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({pix_ready, wr_en, busy} !== 3'b000) $display("FAIL post_reset_idle %0d: got rdy/wr/busy=%b, want 000", i, {pix_ready, wr_en, busy});
      else passed++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({pix_ready, busy} !== 2'b00) $display("FAIL start_abort_idle: got rdy/busy=%b, want 00", {pix_ready, busy});
    else passed++;
    @(negedge clk);
    checks++;
    if ({pix_ready, busy} !== 2'b00) $display("FAIL start_abort_stay: got rdy/busy=%b, want 00", {pix_ready, busy});
    else passed++;
    start_frame();
    checks++;
    if ({pix_ready, busy} !== 2'b11) $display("FAIL lone_start: got rdy/busy=%b, want 11", {pix_ready, busy});
    else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_start_abort_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/coor_scan_gen.md
Name: coor_scan_gen

Overview:
Raster-scan coordinate generator that sits directly upstream of the coordinate-to-address calculator (address = y*79 + x, 7-bit x, 4-bit y, 11-bit address). It accepts a pixel stream over a valid/ready handshake and registers each accepted pixel together with its (x, y) position. The write strobe is timed so that the downstream combinational address stage plus pixel buffer can commit one pixel per cycle. One frame is COLS x ROWS pixels; a start pulse arms each frame.

Parameters:
COLS, 79, pixels per row; x counts 0..COLS-1; must be <= 128.
ROWS, 16, rows per frame; y counts 0..ROWS-1; must be <= 16.
DATA_W, 8, pixel data width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; arms a new frame when idle
abort  input  1  cancels the frame in progress
pix_valid  input  1  upstream pixel valid
pix_data  input  DATA_W  upstream pixel value
pix_ready  output  1  block accepts a pixel this cycle
x  output  7  column of the registered pixel, fed to the address calculator's x
y  output  4  row of the registered pixel, fed to the address calculator's y
wr_en  output  1  one-cycle write strobe for the pixel buffer
wr_data  output  DATA_W  registered pixel value
busy  output  1  frame in progress (state RUN or DONE)
frame_done  output  1  one-cycle pulse after the last pixel is written

Behaviour:
- Reset (async, rst=1): state=IDLE; x=0, y=0, wr_en=0, wr_data=0, frame_done=0, busy=0; internal column/row counters=0.
- States: IDLE, RUN, DONE.
- IDLE: pix_ready=0. When start=1, go to RUN and clear the counters to (0,0).
- RUN: pix_ready=1 (combinational from state). An accept occurs when pix_valid & pix_ready.
- On an accept, the next edge loads x<=col, y<=row, wr_data<=pix_data, and wr_en<=1. Latency is 1 cycle from accept to wr_en.
- wr_en is 0 in every cycle that follows a non-accept cycle. Bubbles on pix_valid simply stall the counters.
- x, y, and wr_data hold their values when wr_en=0.
- Counter advance on an accept:
  - If col==COLS-1: col<=0, row<=row+1.
  - Otherwise: col<=col+1.
  - Counters never take the value COLS or ROWS.
- Last pixel: an accept at col==COLS-1, row==ROWS-1 moves the state to DONE. Counters wrap to (0,0). pix_ready drops in the next cycle.
- DONE: lasts exactly 1 cycle. frame_done=1 (registered), coincident with the cycle after the last pixel's wr_en. Then go to IDLE.
- busy=1 in RUN and DONE.
- start while RUN or DONE is ignored; the frame is not restarted.
- abort (sampled in RUN or DONE) returns to IDLE next edge:
  - No frame_done.
  - A write already registered for the same cycle still completes.
  - An accept coincident with abort is discarded: no wr_en follows.
  - abort has priority over last-pixel detection.
  - abort in IDLE has no effect.
- start and abort together in IDLE: abort wins and the block stays IDLE.
- rst mid-frame: immediate return to reset values; partial frame discarded, no frame_done.
- Width rules:
  - x and y are zero-extended from the counters.
  - Max address = (ROWS-1)*79 + (COLS-1) = 15*79 + 78 = 1263 < 2048, so it fits 11 bits.

Test Plan:
1. Reset then start, pix_valid held 1 for 1264 cycles, data = pixel index mod 256. Required:
   - wr_en high for 1264 consecutive cycles, first at (x=0, y=0, data=0).
   - (x=78, y=0) is followed by (x=0, y=1).
   - Last write at (78, 15, data=0xEF).
   - frame_done for exactly 1 cycle right after the last write, then pix_ready=0 and busy=0.
2. Backpressure: pix_valid toggles 1,0,1,0. Required: wr_en follows accepts with 1-cycle latency; x advances only on accepts; the frame completes after 1264 accepts.
3. abort in the same cycle as the accept of (x=5, y=2). Required:
   - No wr_en for that pixel; state goes to IDLE; no frame_done.
   - The next start restarts at (0, 0).
4. start pulsed mid-frame at (x=40, y=3). Required: ignored, and the scan continues at (41, 3).
5. rst asserted asynchronously mid-frame between edges. Required: all outputs go to reset values immediately; pix_ready=0 until the next start.
6. Simultaneous start and abort in IDLE. Required: stays IDLE with pix_ready=0. A later lone start then enters RUN.
